// File: rtl/video_stream_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_stream_meas                                            |
// | Description : In-fabric receiver/checker for a di/de/hs/vs pixel stream.   |
// |               Measures active width, non-empty line count and a per-frame  |
// |               pixel checksum; flags line-length and frame-height changes   |
// |               and reports when the frame geometry has been stable.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module video_stream_meas #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int FRAME_STABLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   clr_i,
  output logic [CNT_WIDTH-1:0]   width_o,
  output logic [CNT_WIDTH-1:0]   height_o,
  output logic [31:0]            checksum_o,
  output logic [15:0]            frame_cnt_o,
  output logic                   frame_done_o,
  output logic                   geom_vld_o,
  output logic                   err_line_o,
  output logic                   err_frame_o
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [3:0]           C_STABLE  = 4'(FRAME_STABLE);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Registered state
  state_t               state_q,     state_d;
  logic [CNT_WIDTH-1:0] x_cnt_q,     x_cnt_d;
  logic [CNT_WIDTH-1:0] y_cnt_q,     y_cnt_d;
  logic [CNT_WIDTH-1:0] ref_w_q,     ref_w_d;
  logic                 ref_set_q,   ref_set_d;
  logic                 line_bad_q,  line_bad_d;
  logic [31:0]          acc_q,       acc_d;
  logic                 have_prev_q, have_prev_d;
  logic [3:0]           stable_q,    stable_d;
  logic [CNT_WIDTH-1:0] width_q,     width_d;
  logic [CNT_WIDTH-1:0] height_q,    height_d;
  logic [31:0]          checksum_q,  checksum_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 done_q,      done_d;
  logic                 geom_vld_q,  geom_vld_d;
  logic                 err_line_q,  err_line_d;
  logic                 err_frame_q, err_frame_d;

  // Values as they stand once the currently open line has been closed
  logic [CNT_WIDTH-1:0] close_ref_w;
  logic                 close_ref_set;
  logic [CNT_WIDTH-1:0] close_y;
  logic                 close_bad;
  logic                 new_line_err;
  logic                 new_frame_err;
  logic                 frame_clean;
  logic                 line_end;
  logic [31:0]          pix_ext;
  logic [CNT_WIDTH-1:0] x_first;

  assign pix_ext = 32'(di_i);
  // A pixel coincident with a line start is the first pixel of the new line
  assign x_first = {{(CNT_WIDTH-1){1'b0}}, de_i};
  // vs_i implies a line start even when hs_i is absent
  assign line_end = hs_i | vs_i;

  // Line close evaluation: reference width capture, length compare, y count
  always_comb begin
    close_ref_w   = ref_w_q;
    close_ref_set = ref_set_q;
    close_y       = y_cnt_q;
    close_bad     = line_bad_q;
    new_line_err  = 1'b0;
    if (state_q == ST_ACTIVE && line_end && x_cnt_q != '0) begin
      if (!ref_set_q) begin
        close_ref_w   = x_cnt_q;
        close_ref_set = 1'b1;
      end else if (x_cnt_q != ref_w_q) begin
        close_bad    = 1'b1;
        new_line_err = 1'b1;
      end
      if (y_cnt_q != C_CNT_MAX) begin
        close_y = y_cnt_q + 1'b1;
      end
    end
  end

  // Frame close evaluation: height compare against previous frame, cleanliness
  always_comb begin
    new_frame_err = 1'b0;
    frame_clean   = 1'b0;
    if (state_q == ST_ACTIVE && vs_i) begin
      new_frame_err = have_prev_q && (close_y != height_q);
      frame_clean   = !close_bad &&
                      (!have_prev_q || (close_ref_w == width_q && close_y == height_q));
    end
  end

  // Next-state logic: FSM, counters, accumulator and published results
  always_comb begin
    state_d     = state_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    ref_w_d     = ref_w_q;
    ref_set_d   = ref_set_q;
    line_bad_d  = line_bad_q;
    acc_d       = acc_q;
    have_prev_d = have_prev_q;
    stable_d    = stable_q;
    width_d     = width_q;
    height_d    = height_q;
    checksum_d  = checksum_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    geom_vld_d  = geom_vld_q;

    unique case (state_q)
      ST_IDLE: begin
        // Only a frame start is meaningful before the stream is locked
        if (vs_i) begin
          state_d    = ST_ACTIVE;
          x_cnt_d    = x_first;
          y_cnt_d    = '0;
          ref_w_d    = '0;
          ref_set_d  = 1'b0;
          line_bad_d = 1'b0;
          acc_d      = de_i ? pix_ext : 32'd0;
        end
      end

      ST_ACTIVE: begin
        if (vs_i) begin
          // Publish the frame that just ended
          width_d     = close_ref_w;
          height_d    = close_y;
          checksum_d  = acc_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          done_d      = 1'b1;
          have_prev_d = 1'b1;
          if (frame_clean) begin
            if (stable_q != C_STABLE) begin
              stable_d = stable_q + 4'd1;
            end
          end else begin
            stable_d = 4'd0;
          end
          geom_vld_d = (stable_d == C_STABLE);
          // Open the next frame; a coincident pixel belongs to it
          x_cnt_d    = x_first;
          y_cnt_d    = '0;
          ref_w_d    = '0;
          ref_set_d  = 1'b0;
          line_bad_d = 1'b0;
          acc_d      = de_i ? pix_ext : 32'd0;
        end else begin
          if (hs_i) begin
            ref_w_d    = close_ref_w;
            ref_set_d  = close_ref_set;
            y_cnt_d    = close_y;
            line_bad_d = close_bad;
            x_cnt_d    = x_first;
          end else if (de_i && x_cnt_q != C_CNT_MAX) begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
          if (de_i) begin
            acc_d = acc_q + pix_ext;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flags: a fresh error outranks a simultaneous clear
  always_comb begin
    err_line_d  = (err_line_q  & ~clr_i) | new_line_err;
    err_frame_d = (err_frame_q & ~clr_i) | new_frame_err;
  end

  // State register with asynchronous reset; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      ref_w_q     <= '0;
      ref_set_q   <= 1'b0;
      line_bad_q  <= 1'b0;
      acc_q       <= 32'd0;
      have_prev_q <= 1'b0;
      stable_q    <= 4'd0;
      width_q     <= '0;
      height_q    <= '0;
      checksum_q  <= 32'd0;
      frame_cnt_q <= 16'd0;
      done_q      <= 1'b0;
      geom_vld_q  <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      ref_w_q     <= ref_w_d;
      ref_set_q   <= ref_set_d;
      line_bad_q  <= line_bad_d;
      acc_q       <= acc_d;
      have_prev_q <= have_prev_d;
      stable_q    <= stable_d;
      width_q     <= width_d;
      height_q    <= height_d;
      checksum_q  <= checksum_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      geom_vld_q  <= geom_vld_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign width_o      = width_q;
  assign height_o     = height_q;
  assign checksum_o   = checksum_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign frame_done_o = done_q;
  assign geom_vld_o   = geom_vld_q;
  assign err_line_o   = err_line_q;
  assign err_frame_o  = err_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_video_stream_meas                                         |
// | Description : Directed self-checking bench for video_stream_meas.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_video_stream_meas;

  localparam int PW = 8;
  localparam int CW = 16;
  localparam int FS = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] di    = '0;
  logic          de    = 1'b0;
  logic          hs    = 1'b0;
  logic          vs    = 1'b0;
  logic          clr   = 1'b0;
  logic [CW-1:0] width;
  logic [CW-1:0] height;
  logic [31:0]   checksum;
  logic [15:0]   frame_cnt;
  logic          frame_done;
  logic          geom_vld;
  logic          err_line;
  logic          err_frame;

  video_stream_meas #(
    .PIXEL_WIDTH (PW),
    .CNT_WIDTH   (CW),
    .FRAME_STABLE(FS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .di_i        (di),
    .de_i        (de),
    .hs_i        (hs),
    .vs_i        (vs),
    .clr_i       (clr),
    .width_o     (width),
    .height_o    (height),
    .checksum_o  (checksum),
    .frame_cnt_o (frame_cnt),
    .frame_done_o(frame_done),
    .geom_vld_o  (geom_vld),
    .err_line_o  (err_line),
    .err_frame_o (err_frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Outputs captured just after each frame-start edge
  logic          s_done;
  logic [CW-1:0] s_w;
  logic [CW-1:0] s_h;
  logic [31:0]   s_cs;
  logic [15:0]   s_fc;
  logic          s_gv;
  logic          s_el;
  logic          s_ef;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    de = 1'b0; hs = 1'b0; vs = 1'b0; clr = 1'b0; di = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic snap();
    s_done = frame_done; s_w = width; s_h = height; s_cs = checksum;
    s_fc = frame_cnt; s_gv = geom_vld; s_el = err_line; s_ef = err_frame;
  endtask

  // One frame of 16-pixel lines, di = x+1. The leading vs closes the
  // previous frame; outputs are snapshotted right after that edge.
  task automatic send_frame(input int nlines, input int bad_line, input int bad_w,
                            input int gap, input bit extra_hs, input bit clr_at_close);
    int w;
    for (int l = 0; l < nlines; l++) begin
      if (extra_hs && l == 4) begin
        for (int k = 0; k < 3; k++) begin
          hs = 1'b1; tick();
        end
      end
      hs  = 1'b1;
      vs  = (l == 0);
      clr = clr_at_close && (l == bad_line + 1);
      de  = 1'b0;
      tick();
      if (l == 0) snap();
      hs = 1'b0; vs = 1'b0; clr = 1'b0;
      w = (l == bad_line) ? bad_w : 16;
      for (int x = 0; x < w; x++) begin
        de = 1'b1; di = PW'(x + 1);
        tick();
        de = 1'b0; di = '0;
        repeat (gap) tick();
      end
    end
    tick();
  endtask

  task automatic vs_pulse();
    hs = 1'b1; vs = 1'b1; tick(); snap();
    hs = 1'b0; vs = 1'b0; tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- A: continuous de, three full frames ----
    do_reset();
    chk("rst_width",  width,      0);
    chk("rst_height", height,     0);
    chk("rst_cs",     checksum,   0);
    chk("rst_fc",     frame_cnt,  0);
    chk("rst_done",   frame_done, 0);
    chk("rst_gv",     geom_vld,   0);
    chk("rst_errs",   {err_line, err_frame}, 0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("a_f1_done", s_done, 1);
    chk("a_f1_fc",   s_fc,   1);
    chk("a_f1_gv",   s_gv,   0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("a_f2_gv",   s_gv,   1);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("a_w",   s_w,   16);
    chk("a_h",   s_h,   8);
    chk("a_cs",  s_cs,  1088);
    chk("a_fc",  s_fc,  3);
    chk("a_gv",  s_gv,  1);
    chk("a_errs", {s_el, s_ef}, 0);
    chk("a_done_low", frame_done, 0);

    // ---- B: one pixel per four cycles ----
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(8, -1, 0, 3, 1'b0, 1'b0);
    chk("b_w",  s_w,  16);
    chk("b_h",  s_h,  8);
    chk("b_cs", s_cs, 1088);
    chk("b_fc", s_fc, 3);
    chk("b_gv", s_gv, 1);
    chk("b_errs", {s_el, s_ef}, 0);

    // ---- C: short line in frame 2 ----
    do_reset();
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    send_frame(8, 3, 15, 0, 1'b0, 1'b0);
    chk("c_el_set", err_line, 1);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("c_f2_gv", s_gv, 0);
    chk("c_f2_w",  s_w,  16);
    chk("c_f2_cs", s_cs, 1072);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("c_f3_gv", s_gv, 0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("c_f4_gv", s_gv, 1);
    chk("c_el_sticky", err_line, 1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("c_el_clr", err_line, 0);
    chk("c_gv_after_clr", geom_vld, 1);

    // ---- D: frame 2 has 7 lines ----
    do_reset();
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    send_frame(7, -1, 0, 0, 1'b0, 1'b0);
    chk("d_f1_ef", s_ef, 0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("d_f2_h",  s_h,  7);
    chk("d_f2_ef", s_ef, 1);
    chk("d_f2_gv", s_gv, 0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("d_f3_h",  s_h,  8);
    chk("d_f3_ef", s_ef, 1);

    // ---- E: extra empty lines, then an empty frame ----
    do_reset();
    send_frame(8, -1, 0, 0, 1'b1, 1'b0);
    send_frame(8, -1, 0, 0, 1'b1, 1'b0);
    send_frame(8, -1, 0, 0, 1'b1, 1'b0);
    chk("e_h",    s_h, 8);
    chk("e_errs", {s_el, s_ef}, 0);
    chk("e_gv",   s_gv, 1);
    vs_pulse();
    vs_pulse();
    chk("e_empty_w",  s_w,  0);
    chk("e_empty_h",  s_h,  0);
    chk("e_empty_fc", s_fc, 4);
    chk("e_empty_ef", s_ef, 1);

    // ---- F: reset mid-frame, pre-vs traffic, simultaneous clear/error ----
    do_reset();
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("f_pre_fc", frame_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("f_arst_w",  width,     0);
    chk("f_arst_h",  height,    0);
    chk("f_arst_cs", checksum,  0);
    chk("f_arst_fc", frame_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    hs = 1'b1; de = 1'b1; di = 8'hFF; tick();
    hs = 1'b0;
    repeat (5) tick();
    de = 1'b0; di = '0;
    hs = 1'b1; tick(); hs = 1'b0; tick();
    chk("f_idle_fc", frame_cnt, 0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    send_frame(8, -1, 0, 0, 1'b0, 1'b0);
    chk("f_w",  s_w,  16);
    chk("f_h",  s_h,  8);
    chk("f_fc", s_fc, 1);
    chk("f_cs", s_cs, 1088);
    send_frame(8, 3, 15, 0, 1'b0, 1'b1);
    chk("f_clr_vs_err", err_line, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
